// File: rtl/branch_redirect_unit.sv
// Fetch PC owner: sequential advance, back-pressure/stall hold, taken-branch
// redirect with a fixed flush window, and a sticky halt on misaligned targets.
module branch_redirect_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          FLUSH_CYCLES = 2,
  parameter int          CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             br_valid,
  input  logic             br_taken,
  input  logic [31:0]      br_offset,
  input  logic             imem_ready,
  output logic [31:0]      pc,
  output logic             pc_valid,
  output logic             flush,
  output logic             misalign_err,
  output logic [CNT_W-1:0] taken_count
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    HALT  = 2'd2
  } state_t;

  localparam logic [2:0]       FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  state_t           state_reg, state_next;
  logic [31:0]      pc_reg, pc_next;
  logic             pc_valid_reg, pc_valid_next;
  logic             flush_reg, flush_next;
  logic             misalign_reg, misalign_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [2:0]       fcnt_reg, fcnt_next;

  logic [31:0] target;
  logic [31:0] seq_pc;
  logic        advance;
  logic        redirect;

  assign target   = pc_reg + br_offset;
  assign seq_pc   = pc_reg + 32'd4;
  assign advance  = imem_ready & ~stall;
  assign redirect = br_valid & br_taken & (state_reg == RUN) & pc_valid_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= RUN;
      pc_reg       <= RESET_PC;
      pc_valid_reg <= 1'b0;
      flush_reg    <= 1'b0;
      misalign_reg <= 1'b0;
      count_reg    <= '0;
      fcnt_reg     <= 3'd0;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      pc_valid_reg <= pc_valid_next;
      flush_reg    <= flush_next;
      misalign_reg <= misalign_next;
      count_reg    <= count_next;
      fcnt_reg     <= fcnt_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    pc_valid_next = pc_valid_reg;
    flush_next    = flush_reg;
    misalign_next = 1'b0;
    count_next    = count_reg;
    fcnt_next     = fcnt_reg;

    case (state_reg)
      RUN: begin
        flush_next = 1'b0;
        if (!pc_valid_reg) begin
          // First edge out of reset only raises the request; PC stays put.
          pc_valid_next = 1'b1;
        end else if (redirect) begin
          flush_next = 1'b1;
          if (target[1:0] == 2'b00) begin
            pc_next    = target;
            count_next = (count_reg == CNT_MAX) ? count_reg : count_reg + CNT_ONE;
            if (FLUSH_CYCLES > 1) begin
              state_next = FLUSH;
              fcnt_next  = FLUSH_LOAD;
            end
          end else begin
            misalign_next = 1'b1;
            pc_valid_next = 1'b0;
            state_next    = HALT;
          end
        end else if (advance) begin
          pc_next = seq_pc;
        end
      end

      FLUSH: begin
        // Branches seen here belong to squashed instructions.
        flush_next = 1'b1;
        if (advance) begin
          pc_next = seq_pc;
        end
        if (fcnt_reg == 3'd0) begin
          flush_next = 1'b0;
          state_next = RUN;
        end else begin
          fcnt_next = fcnt_reg - 3'd1;
        end
      end

      HALT: begin
        flush_next    = 1'b0;
        pc_valid_next = 1'b0;
      end

      default: begin
        state_next = HALT;
        flush_next = 1'b0;
        pc_valid_next = 1'b0;
      end
    endcase
  end

  assign pc           = pc_reg;
  assign pc_valid     = pc_valid_reg;
  assign flush        = flush_reg;
  assign misalign_err = misalign_reg;
  assign taken_count  = count_reg;

endmodule

// File: tb/tb_branch_redirect_unit.sv
// Vector table + scoreboard bench for branch_redirect_unit; a second instance
// with a one-cycle flush window and a narrow counter covers saturation.
module tb_branch_redirect_unit;

  typedef struct {
    logic        stall;
    logic        br_valid;
    logic        br_taken;
    logic [31:0] br_offset;
    logic        imem_ready;
    logic [31:0] pc;
    logic        pc_valid;
    logic        flush;
    logic        misalign;
    logic [15:0] count;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic        pc_valid;
    logic        flush;
    logic        misalign;
    logic [15:0] count;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, stall, br_valid, br_taken, imem_ready;
  logic [31:0] br_offset;
  logic [31:0] pc;
  logic        pc_valid, flush, misalign_err;
  logic [15:0] taken_count;

  logic        rst2, stall2, br_valid2, br_taken2, imem_ready2;
  logic [31:0] br_offset2;
  logic [31:0] pc2;
  logic        pc_valid2, flush2, misalign_err2;
  logic [2:0]  taken_count2;

  int passed = 0;
  int total  = 0;
  int txn    = 0;
  exp_t sb[$];
  vec_t vecs[$];

  always #5 clk = ~clk;

  branch_redirect_unit #(.RESET_PC(32'h0), .FLUSH_CYCLES(2), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .stall(stall), .br_valid(br_valid), .br_taken(br_taken),
    .br_offset(br_offset), .imem_ready(imem_ready), .pc(pc), .pc_valid(pc_valid),
    .flush(flush), .misalign_err(misalign_err), .taken_count(taken_count)
  );

  branch_redirect_unit #(.RESET_PC(32'h100), .FLUSH_CYCLES(1), .CNT_W(3)) dut2 (
    .clk(clk), .rst(rst2), .stall(stall2), .br_valid(br_valid2), .br_taken(br_taken2),
    .br_offset(br_offset2), .imem_ready(imem_ready2), .pc(pc2), .pc_valid(pc_valid2),
    .flush(flush2), .misalign_err(misalign_err2), .taken_count(taken_count2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic s, input logic bv, input logic bt,
                              input logic [31:0] off, input logic r,
                              input logic [31:0] epc, input logic ev, input logic ef,
                              input logic em, input logic [15:0] ec);
    vec_t v;
    v.stall = s; v.br_valid = bv; v.br_taken = bt; v.br_offset = off; v.imem_ready = r;
    v.pc = epc; v.pc_valid = ev; v.flush = ef; v.misalign = em; v.count = ec;
    return v;
  endfunction

  // Drive one cycle on the selected instance, queue its expectation, compare after the edge.
  task automatic step(input vec_t v, input bit second);
    exp_t e, got;
    if (!second) begin
      stall = v.stall; br_valid = v.br_valid; br_taken = v.br_taken;
      br_offset = v.br_offset; imem_ready = v.imem_ready;
    end else begin
      stall2 = v.stall; br_valid2 = v.br_valid; br_taken2 = v.br_taken;
      br_offset2 = v.br_offset; imem_ready2 = v.imem_ready;
    end
    e.pc = v.pc; e.pc_valid = v.pc_valid; e.flush = v.flush;
    e.misalign = v.misalign; e.count = v.count;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    if (!second) begin
      got.pc = pc; got.pc_valid = pc_valid; got.flush = flush;
      got.misalign = misalign_err; got.count = taken_count;
    end else begin
      got.pc = pc2; got.pc_valid = pc_valid2; got.flush = flush2;
      got.misalign = misalign_err2; got.count = {13'd0, taken_count2};
    end
    txn++;
    $display("txn %0d dut%0d: pc=%08h valid=%0b flush=%0b mis=%0b cnt=%0d",
             txn, second ? 2 : 1, got.pc, got.pc_valid, got.flush, got.misalign, got.count);
    chk("pc", got.pc, e.pc);
    chk("pc_valid", {31'd0, got.pc_valid}, {31'd0, e.pc_valid});
    chk("flush", {31'd0, got.flush}, {31'd0, e.flush});
    chk("misalign_err", {31'd0, got.misalign}, {31'd0, e.misalign});
    chk("taken_count", {16'd0, got.count}, {16'd0, e.count});
  endtask

  initial begin
    rst = 1'b1; stall = 0; br_valid = 0; br_taken = 0; br_offset = '0; imem_ready = 0;
    rst2 = 1'b1; stall2 = 0; br_valid2 = 0; br_taken2 = 0; br_offset2 = '0; imem_ready2 = 0;

    //             st bv bt offset        rdy  pc            v  f  m  cnt
    vecs.push_back(mk(0, 0, 0, 32'h0,        1, 32'h0,        1, 0, 0, 16'd0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        1, 32'h4,        1, 0, 0, 16'd0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        1, 32'h8,        1, 0, 0, 16'd0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        1, 32'hC,        1, 0, 0, 16'd0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        1, 32'h10,       1, 0, 0, 16'd0));
    vecs.push_back(mk(1, 0, 0, 32'h0,        1, 32'h10,       1, 0, 0, 16'd0));
    vecs.push_back(mk(1, 0, 0, 32'h0,        1, 32'h10,       1, 0, 0, 16'd0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h10,       1, 0, 0, 16'd0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        1, 32'h14,       1, 0, 0, 16'd0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        1, 32'h18,       1, 0, 0, 16'd0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        1, 32'h1C,       1, 0, 0, 16'd0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        1, 32'h20,       1, 0, 0, 16'd0));
    vecs.push_back(mk(1, 1, 1, 32'h40,       1, 32'h60,       1, 1, 0, 16'd1));
    vecs.push_back(mk(0, 1, 1, 32'h100,      1, 32'h64,       1, 1, 0, 16'd1));
    vecs.push_back(mk(0, 0, 0, 32'h0,        1, 32'h68,       1, 0, 0, 16'd1));
    vecs.push_back(mk(0, 1, 1, 32'hFFFFFF94, 0, 32'hFFFFFFFC, 1, 1, 0, 16'd2));
    vecs.push_back(mk(0, 0, 0, 32'h0,        1, 32'h0,        1, 1, 0, 16'd2));
    vecs.push_back(mk(0, 0, 0, 32'h0,        1, 32'h4,        1, 0, 0, 16'd2));
    vecs.push_back(mk(0, 1, 0, 32'h40,       1, 32'h8,        1, 0, 0, 16'd2));
    vecs.push_back(mk(0, 0, 1, 32'h40,       1, 32'hC,        1, 0, 0, 16'd2));
    vecs.push_back(mk(0, 1, 1, 32'h6,        1, 32'hC,        0, 1, 1, 16'd2));
    vecs.push_back(mk(0, 1, 1, 32'h4,        1, 32'hC,        0, 0, 0, 16'd2));
    vecs.push_back(mk(0, 0, 0, 32'h0,        1, 32'hC,        0, 0, 0, 16'd2));

    #2;
    chk("reset_pc", pc, 32'h0);
    chk("reset_pc_valid", {31'd0, pc_valid}, 32'd0);
    chk("reset_flush", {31'd0, flush}, 32'd0);
    chk("reset_count", {16'd0, taken_count}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) step(vecs[i], 1'b0);

    // Reset out of HALT, then an async reset in the middle of a flush window.
    rst = 1'b1;
    #1;
    chk("halt_reset_pc", pc, 32'h0);
    chk("halt_reset_misalign", {31'd0, misalign_err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step(mk(0, 0, 0, 32'h0, 1, 32'h0, 1, 0, 0, 16'd0), 1'b0);
    step(mk(0, 1, 1, 32'h40, 1, 32'h40, 1, 1, 0, 16'd1), 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_flush", {31'd0, flush}, 32'd0);
    chk("async_rst_count", {16'd0, taken_count}, 32'd0);
    chk("async_rst_pc", pc, 32'h0);
    chk("async_rst_pc_valid", {31'd0, pc_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step(mk(0, 0, 0, 32'h0, 1, 32'h0, 1, 0, 0, 16'd0), 1'b0);

    // One-cycle flush window: back-to-back redirects, counter saturates at 7.
    @(negedge clk);
    rst2 = 1'b0;
    step(mk(0, 0, 0, 32'h0, 1, 32'h100, 1, 0, 0, 16'd0), 1'b1);
    for (int k = 1; k <= 9; k++) begin
      step(mk(1, 1, 1, 32'h8, 0, 32'h100 + 32'(8 * k), 1, 1, 0, 16'((k > 7) ? 7 : k)), 1'b1);
    end
    step(mk(0, 0, 0, 32'h0, 1, 32'h14C, 1, 0, 0, 16'd7), 1'b1);

    if (sb.size() != 0) begin
      total++;
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/branch_redirect_unit.md
Name: branch_redirect_unit

Overview:
Fetch-side consumer of the resolved branch decision (taken flag plus PC-relative offset) produced in EX. It owns the fetch PC register and handles sequential advance, instruction-memory back-pressure and hazard stalls. On a taken branch it redirects the PC, flushes the younger pipeline stages for a fixed bubble window, and traps misaligned targets. It sits between the EX-stage branch comparator and the IF stage / instruction memory.

Parameters:
RESET_PC, 32'h0000_0000, fetch address loaded on reset
FLUSH_CYCLES, 2, number of consecutive cycles flush is held after a redirect (legal range 1..7)
CNT_W, 16, width of the taken-branch counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
stall  in  1  hazard unit holds fetch; PC must not advance
br_valid  in  1  EX holds a resolved branch this cycle
br_taken  in  1  branch condition true (comparator jump_enable)
br_offset  in  32  signed offset, already compensated for pipeline depth, added to the current pc
imem_ready  in  1  instruction memory accepts the presented fetch address this cycle
pc  out  32  current fetch address
pc_valid  out  1  fetch request valid
flush  out  1  kill IF/ID and ID/EX contents
misalign_err  out  1  one-cycle pulse on a misaligned branch target
taken_count  out  CNT_W  saturating count of accepted redirects

Behaviour:
- Reset (async, any time, including mid-flush): pc=RESET_PC, pc_valid=0, flush=0, misalign_err=0, taken_count=0, state=RUN, flush counter=0. On the first rising edge after rst deasserts, pc_valid becomes 1. Until then, nothing advances.
- All outputs are registered.
- target = pc + br_offset, modulo 2^32 (wrap, no overflow flag). Sequential next = pc + 4, modulo 2^32 (0xFFFF_FFFC -> 0).
- redirect = br_valid & br_taken & (state==RUN) & pc_valid.
- State RUN:
  - If redirect and target[1:0]==0: on the next edge, pc<=target, flush<=1, flush counter<=FLUSH_CYCLES-1, taken_count increments (saturating at all-ones), and the state moves to FLUSH. If FLUSH_CYCLES==1, the state stays RUN and flush is high for exactly one cycle.
  - Redirect priority: redirect wins over stall and over imem_ready=0.
  - If redirect and target[1:0]!=0: no PC change, misalign_err<=1 for one cycle, flush<=1 for one cycle, and the state moves to HALT. taken_count is unchanged.
  - Otherwise: pc<=pc+4 iff imem_ready & ~stall, else pc holds. flush<=0.
  - br_valid with br_taken=0: no effect.
- State FLUSH:
  - flush stays 1. Each cycle the counter decrements; when the counter is 0 at an edge, flush<=0 and the state returns to RUN. flush is therefore high for exactly FLUSH_CYCLES consecutive cycles.
  - br_valid/br_taken are ignored (squashed instructions).
  - pc advances by 4 on imem_ready & ~stall.
- State HALT: pc_valid=0, pc frozen, flush=0, all inputs ignored. Only rst exits this state.
- misalign_err is never high for two consecutive cycles.
- stall and imem_ready have no effect on flush timing.

Test Plan:
- Reset then imem_ready=1, stall=0 for 4 cycles -> pc_valid rises on the first edge; pc goes 0x0, 0x4, 0x8, 0xC, 0x10.
- At pc=0x10: stall=1 for 2 cycles, then imem_ready=0 for 1 cycle -> pc holds 0x10 for 3 cycles, then advances to 0x14.
- At pc=0x20: br_valid=1, br_taken=1, br_offset=0x40, stall=1 -> next pc=0x60, flush high for exactly 2 cycles, taken_count=1. A second taken branch presented during the flush is ignored.
- At pc=0x20: br_offset=-0x24 -> target 0xFFFF_FFFC; then 1 sequential step -> pc=0x0000_0000 (wrap).
- At pc=0x30: br_offset=0x6 -> misalign_err pulses 1 cycle, pc stays 0x30, pc_valid=0 from the next cycle. Asserting rst returns pc to RESET_PC.
- Assert rst mid-flush (cycle 1 of 2) -> flush=0 and taken_count=0 immediately (async). Also: force taken_count to 0xFFFF by repeated redirects -> it stays 0xFFFF.
